mult_share_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one sequential signed multiplier among NUM_REQ requesters.

---
 rtl/mult_share_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin front end that shares one sequential signed multiplier
// between NUM_REQ requesters. It accepts one operand pair at a time, starts
// the multiplier, waits for its done pulse and returns the product to the
// requester that won arbitration.
//
// Optional feature macro: MULT_ARB_TIMEOUT_EN
//   When this macro is defined, a watchdog aborts a WAIT that lasts
//   TIMEOUT_CYCLES cycles and pulses err_timeout.
//   When it is undefined, WAIT is held until mul_ready arrives and
//   err_timeout is tied to 0.
module mult_share_arbiter #(
  parameter int NUMBITS        = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*NUMBITS-1:0]        req_a,
  input  logic [NUM_REQ*NUMBITS-1:0]        req_b,
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic signed [2*NUMBITS-1:0]       resp_product,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id,
  output logic                              busy,
  output logic                              err_timeout,
  output logic                              mul_start,
  output logic signed [NUMBITS-1:0]         mul_numA,
  output logic signed [NUMBITS-1:0]         mul_numB,
  input  logic                              mul_ready,
  input  logic signed [2*NUMBITS-1:0]       mul_product
);

  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("mult_share_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mult_share_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [IDW-1:0]              rr_ptr;
  logic [IDW-1:0]              winner;
  logic signed [NUMBITS-1:0]   op_a;
  logic signed [NUMBITS-1:0]   op_b;
  logic signed [2*NUMBITS-1:0] prod_q;
  logic                        any_valid;
  logic                        resp_done;
  logic                        timeout_hit;

  // First valid requester found by scanning from the round-robin pointer
  // upward with wrap-around.
  function automatic logic [IDW-1:0] pick_winner(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] w;
    logic [IDW:0]   idx;
    w = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (v[idx[IDW-1:0]]) w = idx[IDW-1:0];
    end
    return w;
  endfunction

  // Index after g, wrapping NUM_REQ-1 back to 0.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] g);
    return (g == IDW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  assign any_valid    = |req_valid;
  assign winner       = pick_winner(req_valid, rr_ptr);
  assign resp_done    = (state == S_RESP) && resp_ready[grant_id];
  assign mul_numA     = op_a;
  assign mul_numB     = op_b;
  assign resp_product = prod_q;
  assign err_timeout  = timeout_hit;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Watchdog: counts cycles spent in WAIT, restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (reset || state != S_WAIT) to_cnt <= '0;
    else                          to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_WAIT) && !mul_ready &&
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic for the accept/issue/wait/respond sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (any_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mul_ready)        state_nxt = S_RESP;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_RESP:  if (resp_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore/Mealy outputs: accept pulse, multiplier start, response valid.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    mul_start  = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_IDLE:  if (any_valid) req_ready[winner] = 1'b1;
      S_ISSUE: mul_start = 1'b1;
      S_WAIT:  ;
      S_RESP:  resp_valid[grant_id] = 1'b1;
      default: ;
    endcase
  end

  // Grant, operand, product and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      op_a     <= '0;
      op_b     <= '0;
      prod_q   <= '0;
    end else begin
      if (state == S_IDLE && any_valid) begin
        grant_id <= winner;
        op_a     <= req_a[winner*NUMBITS +: NUMBITS];
        op_b     <= req_b[winner*NUMBITS +: NUMBITS];
      end
      if (state == S_WAIT && mul_ready) prod_q <= mul_product;
      if (resp_done || timeout_hit)     rr_ptr <= next_idx(grant_id);
    end
  end

endmodule
